nrisc_pc_stack_unit: RTL
========================

Name: nrisc_pc_stack_unit

Overview:
- Parametrised program-counter and return-stack controller for the NRISC core fetch stage.
- Drives the instruction-memory address and fetch handshake, and presents fetched instructions (or NOP bubbles) to the core.
- Executes jump/call/return redirects and vectors interrupts through a configurable vector table.
- Exposes the top-of-stack link address to the register file.

Parameters:
- ADDR_W, 10, instruction address width
- DATA_W, 16, core register width; ADDR_W <= DATA_W
- DEPTH, 8, return-stack entries, power of two, >= 2
- LVL_W, 4, stack-level width = log2(DEPTH)+1
- RESET_VEC, 0, PC value after reset
- VEC_BASE, 16, interrupt vector table base address
- VEC_STRIDE_LOG2, 1, vector spacing = 2^VEC_STRIDE_LOG2 words

Ports:
- clk  in  1  clock
- rst  in  1  reset
- imem_addr  out  ADDR_W  fetch address, equals pc
- imem_req  out  1  fetch request
- imem_rdata  in  16  fetched instruction
- imem_ready  in  1  fetch data valid this cycle
- instr_out  out  16  instruction to core; 16'h0000 (NOP) when not valid
- instr_valid  out  1  instr_out carries a real instruction
- pc_ctrl  in  2  00 sequential, 01 jump, 10 call, 11 return
- pc_target  in  ADDR_W  jump/call target
- irq_req  in  1  interrupt request, level
- irq_ch  in  8  interrupt channel
- irq_ack  out  1  one-cycle pulse on interrupt entry
- in_isr  out  1  at least one interrupt frame on stack
- link_addr  out  DATA_W  top-of-stack address, zero-extended; 0 when empty
- stack_level  out  LVL_W  occupied entries, 0..DEPTH
- stack_ovf  out  1  sticky overflow flag
- stack_unf  out  1  sticky underflow flag

Behaviour:
- Reset: rst is synchronous and active-high on clk. It sets:
  - pc = RESET_VEC, sp = 0, isr_depth = 0, flush = 0;
  - stack_ovf = 0, stack_unf = 0, irq_ack = 0.
- imem_req = ~rst & ~flush.
- instr_valid = imem_req & imem_ready & (pc_ctrl==00) & ~irq_take.
- instr_out = instr_valid ? imem_rdata : 0.
- flush: set for exactly one cycle after any taken redirect or interrupt entry.
  - While flush=1, pc_ctrl and irq_req are ignored and pc holds.
  - Redirect latency is therefore 1 bubble cycle.
- Sequential (00): when imem_ready=1, pc <= pc+1, wrapping modulo 2^ADDR_W. When imem_ready=0, pc holds.
- Jump (01): pc <= pc_target.
- Call (10): push {tag=0, pc+1} at stack[sp], sp++, pc <= pc_target.
- Return (11): pop. pc <= stack[sp-1].addr, sp--. If the popped tag is 1, isr_depth--.
- Redirects (01/10/11) are taken regardless of imem_ready.
- Each stack entry is ADDR_W+1 bits: address plus ISR tag.
- Interrupt, irq_take = irq_req & ~flush & ~rst & (pc_ctrl==00) & irq_allowed. On irq_take:
  - push {tag=1, pc} (the suppressed instruction is re-fetched on return);
  - pc <= VEC_BASE + (irq_ch << VEC_STRIDE_LOG2), truncated to ADDR_W;
  - isr_depth++, irq_ack=1 next cycle.
- Non-sequential pc_ctrl has priority over irq; the interrupt is deferred while pc_ctrl != 00.
- Overflow:
  - call or irq with sp==DEPTH: the redirect is still taken, the push is dropped, and stack_ovf <= 1.
  - isr_depth still increments on irq.
- Underflow:
  - return with sp==0: treated as sequential (pc <= pc+1 if imem_ready, no flush), stack_unf <= 1.
- Sticky flags clear only on rst.
- in_isr = (isr_depth != 0).
- stack_level = sp.
- link_addr = sp ? stack[sp-1].addr : 0.
- rst asserted mid-flush or mid-stall wins over all other activity in that cycle.

Optional Feature:
- NRISC_PC_IRQ_NEST_EN defined:
  - irq_allowed = 1, so nested interrupts are accepted inside an ISR;
  - isr_depth is LVL_W bits.
- Not defined:
  - irq_allowed = ~in_isr;
  - isr_depth is 1 bit;
  - requests during an ISR stay pending (level) until the tagged return.

Test Plan:
- Reset then imem_ready=1, pc_ctrl=00 for 4 cycles -> imem_addr 0,1,2,3; instr_valid=1 each cycle.
- imem_ready=0 for 3 cycles at pc=5 -> pc holds 5, instr_valid=0, instr_out=0.
- Call at pc=3 with pc_target=0x40, then return -> flush bubble; link_addr=4, stack_level=1; after return pc=4, stack_level=0, one bubble.
- DEPTH+1 consecutive calls -> stack_level saturates at 8, stack_ovf=1; then return with empty stack -> stack_unf=1 and pc advances sequentially.
- irq_req with irq_ch=3 at pc=7 -> irq_ack pulse, pc=16+6=22, in_isr=1; tagged return -> pc=7, in_isr=0.
- Second irq during ISR -> without the macro it is deferred until the return; with NRISC_PC_IRQ_NEST_EN it is taken and in_isr stays 1 until both returns.

Source files
------------

// File: rtl/nrisc_pc_stack_unit.sv
// -----------------------------------------------------------------------------
// nrisc_pc_stack_unit
//
// Program counter and return-stack controller for the NRISC fetch stage.
// Drives the instruction-memory fetch address and request, forwards fetched
// instructions (or NOP bubbles) to the core, executes jump/call/return
// redirects and vectors interrupts through a table at VEC_BASE with a spacing
// of 2^VEC_STRIDE_LOG2 words. Every taken redirect or interrupt entry is
// followed by exactly one flush (bubble) cycle.
//
// Build option:
//   NRISC_PC_IRQ_NEST_EN - when defined, interrupts are accepted inside an ISR
//                          and the ISR nesting depth is tracked with LVL_W
//                          bits. When undefined, a single ISR level exists and
//                          requests raised inside an ISR stay pending until
//                          the tagged return.
//
// Ports:
//   clk, rst      - clock; synchronous active-high reset
//   imem_addr     - fetch address (the current pc)
//   imem_req      - fetch request, low during reset and flush
//   imem_rdata    - fetched instruction
//   imem_ready    - fetch data valid this cycle
//   instr_out     - instruction to core, 16'h0000 (NOP) when not valid
//   instr_valid   - instr_out carries a real instruction
//   pc_ctrl       - 00 sequential, 01 jump, 10 call, 11 return
//   pc_target     - jump/call target
//   irq_req       - level interrupt request
//   irq_ch        - interrupt channel
//   irq_ack       - one-cycle pulse following interrupt entry
//   in_isr        - at least one interrupt frame on the stack
//   link_addr     - top-of-stack address, zero-extended, 0 when empty
//   stack_level   - occupied stack entries
//   stack_ovf     - sticky overflow flag
//   stack_unf     - sticky underflow flag
// -----------------------------------------------------------------------------
module nrisc_pc_stack_unit #(
    parameter int ADDR_W          = 10,
    parameter int DATA_W          = 16,
    parameter int DEPTH           = 8,
    parameter int LVL_W           = 4,
    parameter int RESET_VEC       = 0,
    parameter int VEC_BASE        = 16,
    parameter int VEC_STRIDE_LOG2 = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ready,
    output logic [15:0]       instr_out,
    output logic              instr_valid,
    input  logic [1:0]        pc_ctrl,
    input  logic [ADDR_W-1:0] pc_target,
    input  logic              irq_req,
    input  logic [7:0]        irq_ch,
    output logic              irq_ack,
    output logic              in_isr,
    output logic [DATA_W-1:0] link_addr,
    output logic [LVL_W-1:0]  stack_level,
    output logic              stack_ovf,
    output logic              stack_unf
);

    // Stack index width: DEPTH is a power of two, so log2(DEPTH) = LVL_W-1.
    localparam int IDX_W = LVL_W - 1;

`ifdef NRISC_PC_IRQ_NEST_EN
    localparam int ISR_W = LVL_W;
`else
    localparam int ISR_W = 1;
`endif

    // Architectural state
    logic [ADDR_W-1:0] pc_r;
    logic [LVL_W-1:0]  sp_r;
    logic [ISR_W-1:0]  isr_depth_r;
    logic              flush_r;
    logic              ovf_r;
    logic              unf_r;
    logic              irq_ack_r;
    // Entry layout: {isr_tag, return_address}
    logic [ADDR_W:0]   stack_r [DEPTH];

    // Decoded / derived values
    logic              seq_s;
    logic              irq_allowed_s;
    logic              irq_take_s;
    logic              stack_empty_s;
    logic              stack_full_s;
    logic [IDX_W-1:0]  push_idx_s;
    logic [IDX_W-1:0]  top_idx_s;
    logic [ADDR_W:0]   top_entry_s;
    logic [ADDR_W-1:0] pc_inc_s;
    logic [ADDR_W-1:0] vec_addr_s;
    logic [ISR_W-1:0]  isr_inc_s;
    logic              push_en_s;
    logic [ADDR_W:0]   push_data_s;
    logic              in_isr_s;

    // Decode control, stack pointers, interrupt qualification and vector address
    always_comb begin
        seq_s         = (pc_ctrl == 2'b00);
        stack_empty_s = (sp_r == LVL_W'(0));
        stack_full_s  = (sp_r == LVL_W'(DEPTH));
        push_idx_s    = sp_r[IDX_W-1:0];
        top_idx_s     = push_idx_s - IDX_W'(1);
        top_entry_s   = stack_r[top_idx_s];
        pc_inc_s      = pc_r + ADDR_W'(1);
        // Vector arithmetic is done at integer width and truncated to the pc.
        vec_addr_s    = ADDR_W'(VEC_BASE + (int'(irq_ch) << VEC_STRIDE_LOG2));
        in_isr_s      = (isr_depth_r != ISR_W'(0));
        // Saturating increment keeps the depth counter from wrapping to zero.
        if (isr_depth_r == {ISR_W{1'b1}}) begin
            isr_inc_s = isr_depth_r;
        end else begin
            isr_inc_s = isr_depth_r + ISR_W'(1);
        end
`ifdef NRISC_PC_IRQ_NEST_EN
        irq_allowed_s = 1'b1;
`else
        irq_allowed_s = ~in_isr_s;
`endif
        // Interrupts only preempt sequential fetch; redirects defer them.
        irq_take_s    = irq_req & ~flush_r & ~rst & seq_s & irq_allowed_s;
        // Overflowing pushes are dropped; the redirect itself still happens.
        push_en_s     = ~rst & ~flush_r & ~stack_full_s &
                        ((pc_ctrl == 2'b10) | irq_take_s);
        // Interrupt frames store the suppressed pc so it is re-fetched on return.
        if (irq_take_s) begin
            push_data_s = {1'b1, pc_r};
        end else begin
            push_data_s = {1'b0, pc_inc_s};
        end
    end

    // Core-facing and status outputs derived from the registered state
    always_comb begin
        imem_addr   = pc_r;
        imem_req    = ~rst & ~flush_r;
        instr_valid = ~rst & ~flush_r & imem_ready & seq_s & ~irq_take_s;
        if (instr_valid) begin
            instr_out = imem_rdata;
        end else begin
            instr_out = 16'h0000;
        end
        if (stack_empty_s) begin
            link_addr = DATA_W'(0);
        end else begin
            link_addr = DATA_W'(top_entry_s[ADDR_W-1:0]);
        end
        irq_ack     = irq_ack_r;
        in_isr      = in_isr_s;
        stack_level = sp_r;
        stack_ovf   = ovf_r;
        stack_unf   = unf_r;
    end

    // Return-stack storage; contents need no reset because sp gates every read
    always_ff @(posedge clk) begin
        if (push_en_s) begin
            stack_r[push_idx_s] <= push_data_s;
        end
    end

    // Program counter, stack pointer, ISR depth, flush and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r        <= ADDR_W'(RESET_VEC);
            sp_r        <= LVL_W'(0);
            isr_depth_r <= ISR_W'(0);
            flush_r     <= 1'b0;
            ovf_r       <= 1'b0;
            unf_r       <= 1'b0;
            irq_ack_r   <= 1'b0;
        end else if (flush_r) begin
            // Bubble cycle: all requests ignored, pc holds.
            flush_r   <= 1'b0;
            irq_ack_r <= 1'b0;
        end else begin
            irq_ack_r <= irq_take_s;
            case (pc_ctrl)
                2'b00: begin
                    if (irq_take_s) begin
                        if (stack_full_s) begin
                            ovf_r <= 1'b1;
                        end else begin
                            sp_r <= sp_r + LVL_W'(1);
                        end
                        pc_r        <= vec_addr_s;
                        isr_depth_r <= isr_inc_s;
                        flush_r     <= 1'b1;
                    end else if (imem_ready) begin
                        pc_r <= pc_inc_s;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                2'b01: begin
                    pc_r    <= pc_target;
                    flush_r <= 1'b1;
                end
                2'b10: begin
                    if (stack_full_s) begin
                        ovf_r <= 1'b1;
                    end else begin
                        sp_r <= sp_r + LVL_W'(1);
                    end
                    pc_r    <= pc_target;
                    flush_r <= 1'b1;
                end
                2'b11: begin
                    if (stack_empty_s) begin
                        // Nothing to pop: behave as a sequential step, no bubble.
                        unf_r <= 1'b1;
                        if (imem_ready) begin
                            pc_r <= pc_inc_s;
                        end else begin
                            pc_r <= pc_r;
                        end
                    end else begin
                        pc_r    <= top_entry_s[ADDR_W-1:0];
                        sp_r    <= sp_r - LVL_W'(1);
                        flush_r <= 1'b1;
                        if (top_entry_s[ADDR_W] && in_isr_s) begin
                            isr_depth_r <= isr_depth_r - ISR_W'(1);
                        end else begin
                            isr_depth_r <= isr_depth_r;
                        end
                    end
                end
                default: begin
                    pc_r <= pc_r;
                end
            endcase
        end
    end

endmodule
